// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory responder: bus widths, FSM encoding, byte-lane helper.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int BE_W  = XLEN / 8;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    // Expands one enable bit per byte into a full-word bit mask.
    function automatic logic [XLEN-1:0] be_mask(input logic [BE_W-1:0] be);
        logic [XLEN-1:0] m;
        for (int i = 0; i < BE_W; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised storage with per-byte write enables and registered (synchronous) read.
// Read returns the word as it was before a same-edge write; contents are never reset.
module dmem_ram
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic            clk,
    input  logic            we,
    input  logic [BE_W-1:0] be,
    input  logic [AW-1:0]   widx,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[widx] <= (mem_q[widx] & ~be_mask(be)) | (wdata & be_mask(be));
        end
        rdata <= mem_q[widx];
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts in IDLE, waits WAIT_CYCLES+1 edges, then
// holds the response until the CPU consumes it. Access and error status are fixed at acceptance.
module dmem_responder
    import riscv_pkg::*;
#(
    parameter int              DEPTH_WORDS = 1024,
    parameter int              WAIT_CYCLES = 2,
    parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [BE_W-1:0] req_be,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    dmem_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            we_q;
    logic            err_q;
    logic [AW-1:0]   widx_q;
    logic [XLEN-1:0] wdata_q;
    logic [BE_W-1:0] be_q;

    logic            accept;
    logic            commit;
    logic            ram_we;
    logic            req_err;
    logic [XLEN-1:0] offset;
    logic [XLEN-1:0] word_idx;
    logic [XLEN-1:0] ram_rdata;

    // Subtraction wraps, so addresses below BASE_ADDR land far out of range.
    assign offset   = req_addr - BASE_ADDR;
    assign word_idx = offset >> 2;
    assign req_err  = (req_addr[1:0] != 2'b00) || (word_idx >= XLEN'(DEPTH_WORDS));

    assign accept = req_valid && req_ready;
    assign commit = (state_q == ST_WAIT) && (cnt_q == '0);
    assign ram_we = commit && we_q && !err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            widx_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            err_q   <= req_err;
            widx_q  <= word_idx[AW-1:0];
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // RAM re-reads the same index every cycle and is only written on the commit edge,
    // so its output stays stable for the whole RESP phase.
    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        resp_valid = (state_q == ST_RESP);
        resp_err   = (state_q == ST_RESP) && err_q;
        resp_rdata = '0;
        if ((state_q == ST_RESP) && !err_q && !we_q) begin
            resp_rdata = ram_rdata;
        end
    end

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (be_q),
        .widx  (widx_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance for the main sequence and a
// WAIT_CYCLES=0 instance (small, offset base) for back-to-back throughput.
module tb_dmem_responder;

    localparam int          W2 = 2;
    localparam int          D2 = 1024;
    localparam logic [31:0] B2 = 32'h0000_0000;
    localparam int          D0 = 16;
    localparam logic [31:0] B0 = 32'h1000_0000;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_be;

    logic        req_valid0, req_ready0, req_we0, resp_valid0, resp_ready0, resp_err0;
    logic [31:0] req_addr0, req_wdata0, resp_rdata0;
    logic [3:0]  req_be0;

    dmem_responder #(.DEPTH_WORDS(D2), .WAIT_CYCLES(W2), .BASE_ADDR(B2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH_WORDS(D0), .WAIT_CYCLES(0), .BASE_ADDR(B0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0)
    );

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    exp_t sb0[$];
    logic [31:0] mem2 [int];
    logic [31:0] mem0 [int];
    req_t stim0 [12];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: byte-lane loop over an associative memory, one per instance.
    task automatic model(input bit sel, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, output exp_t e);
        logic [31:0] base, off, word;
        int depth, idx;
        base  = sel ? B0 : B2;
        depth = sel ? D0 : D2;
        off   = addr - base;
        e.err   = (addr[1:0] != 2'b00) || ((off >> 2) >= 32'(depth));
        e.rdata = 32'h0;
        if (!e.err) begin
            idx = int'(off >> 2);
            if (sel) word = mem0.exists(idx) ? mem0[idx] : 32'hx;
            else     word = mem2.exists(idx) ? mem2[idx] : 32'hx;
            if (we) begin
                for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = wdata[8*i +: 8];
                if (be != 4'b0000) begin
                    if (sel) mem0[idx] = word;
                    else     mem2[idx] = word;
                end
            end else begin
                e.rdata = word;
            end
        end
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int hold, input string tag);
        exp_t e, got;
        int   lat;
        bit   ok;
        model(1'b0, we, addr, wdata, be, e);
        sb.push_back(e);
        @(negedge clk);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk({tag, "_accept"}, 32'(ok), 32'd1);
        if (!ok) begin void'(sb.pop_front()); return; end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom; req_be = ~be;
        @(negedge clk);
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(W2 + 1));
        got = sb.pop_front();
        chk({tag, "_err"}, 32'(resp_err), 32'(got.err));
        chk({tag, "_rdata"}, resp_rdata, got.rdata);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
            chk({tag, "_hold_rdata"}, resp_rdata, got.rdata);
            chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   k, nresp, last_acc, lat_seen;
        bit   seen;

        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0;
        resp_ready = 1'b0;
        req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = 32'h0; req_wdata0 = 32'h0; req_be0 = 4'h0;
        resp_ready0 = 1'b1;

        stim0[0]  = '{1'b1, 32'h1000_0000, 32'hCAFE_F00D, 4'b1111};
        stim0[1]  = '{1'b0, 32'h1000_0000, 32'h0,         4'b0000};
        stim0[2]  = '{1'b1, 32'h1000_0000, 32'h00BB_0000, 4'b0100};
        stim0[3]  = '{1'b0, 32'h1000_0000, 32'h0,         4'b1111};
        stim0[4]  = '{1'b1, 32'h1000_003C, 32'h0BAD_CAFE, 4'b1111};
        stim0[5]  = '{1'b0, 32'h1000_003C, 32'h0,         4'b0000};
        stim0[6]  = '{1'b0, 32'h1000_0040, 32'h0,         4'b0000};
        stim0[7]  = '{1'b0, 32'h0000_0000, 32'h0,         4'b0000};
        stim0[8]  = '{1'b1, 32'h1000_0000, 32'hFFFF_FFFF, 4'b0000};
        stim0[9]  = '{1'b0, 32'h1000_0000, 32'h0,         4'b0000};
        stim0[10] = '{1'b1, 32'h1000_0001, 32'hFFFF_FFFF, 4'b1111};
        stim0[11] = '{1'b0, 32'h1000_0000, 32'h0,         4'b0000};

        // Reset is asynchronous: outputs must be quiet before any clock edge.
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 0, "st10_full");
        do_req(1'b0, 32'h10, 32'h0, 4'b0000, 0, "ld10_a");
        do_req(1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 0, "st10_byte0");
        do_req(1'b0, 32'h10, 32'h0, 4'b1010, 0, "ld10_b");
        do_req(1'b0, 32'h12, 32'h0, 4'b1111, 0, "ld_misaligned");
        do_req(1'b0, 32'(4 * D2), 32'h0, 4'b1111, 0, "ld_out_of_range");
        do_req(1'b1, 32'(4 * D2 - 4), 32'hA5A5_5A5A, 4'b1111, 0, "st_last_word");
        do_req(1'b0, 32'(4 * D2 - 4), 32'h0, 4'b0000, 0, "ld_last_word");
        do_req(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 0, "st_be_none");
        do_req(1'b1, 32'h11, 32'h1234_5678, 4'b1111, 0, "st_misaligned");
        do_req(1'b1, 32'(4 * D2), 32'h1234_5678, 4'b1111, 0, "st_out_of_range");
        do_req(1'b0, 32'h10, 32'h0, 4'b0000, 5, "ld10_hold");

        // Store accepted, then reset one cycle later: must abort without commit or response.
        do_req(1'b1, 32'h20, 32'h1122_3344, 4'b1111, 0, "st20_old");
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h5566_7788; req_be = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("abort_rst_valid", 32'(resp_valid), 32'd0);
        chk("abort_rst_rdata", resp_rdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | resp_valid;
        end
        chk("abort_no_resp", 32'(seen), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        do_req(1'b0, 32'h20, 32'h0, 4'b0000, 0, "ld20_after_abort");

        // Zero-wait instance, requests always offered, response always consumed.
        k = 0; nresp = 0; last_acc = -100;
        for (int c = 0; c < 300 && nresp < 12; c++) begin
            @(negedge clk);
            if (resp_valid0) begin
                if (sb0.size() == 0) begin
                    chk("b2b_spurious_resp", 32'(sb0.size()), 32'd1);
                end else begin
                    e = sb0.pop_front();
                    lat_seen = c - last_acc;
                    chk("b2b_latency", 32'(lat_seen), 32'd1);
                    chk("b2b_err", 32'(resp_err0), 32'(e.err));
                    chk("b2b_rdata", resp_rdata0, e.rdata);
                    nresp++;
                end
            end
            if (k < 12) begin
                req_valid0 = 1'b1;
                req_we0 = stim0[k].we; req_addr0 = stim0[k].addr;
                req_wdata0 = stim0[k].wdata; req_be0 = stim0[k].be;
                if (req_ready0) begin
                    model(1'b1, stim0[k].we, stim0[k].addr, stim0[k].wdata, stim0[k].be, e);
                    sb0.push_back(e);
                    if (k > 0) chk("b2b_period", 32'(c + 1 - last_acc), 32'd3);
                    last_acc = c + 1;
                    k++;
                end
            end else begin
                req_valid0 = 1'b0;
            end
        end
        chk("b2b_resp_count", 32'(nresp), 32'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
